// File: rtl/aes_egress_if.sv
// Handshake bundle for aes_egress: upstream issue side, cipher side and AXI-Stream output.
// master = the egress block, slave = its surroundings (upstream, cipher, stream sink).
interface aes_egress_if #(
    parameter int WORD = 32,
    parameter int NB   = 4
);
    localparam int BW        = WORD * NB;
    localparam int STRBWIDTH = BW / 8;

    logic                 s_valid;
    logic                 s_ready;
    logic                 s_last;
    logic [STRBWIDTH-1:0] s_strb;
    logic                 c_valid;
    logic                 c_o_valid;
    logic [BW-1:0]        c_o_block;
    logic                 m_tvalid;
    logic                 m_tready;
    logic [BW-1:0]        m_tdata;
    logic                 m_tlast;
    logic [STRBWIDTH-1:0] m_tstrb;
    logic                 o_error;

    modport master (
        input  s_valid, s_last, s_strb, c_o_valid, c_o_block, m_tready,
        output s_ready, c_valid, m_tvalid, m_tdata, m_tlast, m_tstrb, o_error
    );

    modport slave (
        output s_valid, s_last, s_strb, c_o_valid, c_o_block, m_tready,
        input  s_ready, c_valid, m_tvalid, m_tdata, m_tlast, m_tstrb, o_error
    );
endinterface

// File: rtl/aes_egress.sv
// AES egress: credit-gated issue, sideband realignment and output FIFO with AXI-Stream handshake.
// Optional sticky misalignment/overflow checker enabled by macro AES_EGRESS_CHECK_EN.
module aes_egress #(
    parameter int WORD    = 32,
    parameter int NB      = 4,
    parameter int LATENCY = 11,
    parameter int DEPTH   = 16
) (
    input logic         clk,
    input logic         rst,
    aes_egress_if.master bus
);
    localparam int BW        = WORD * NB;
    localparam int STRBWIDTH = BW / 8;
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int AW        = $clog2(DEPTH);
    localparam int EW        = BW + 1 + STRBWIDTH;
    localparam int SBW       = STRBWIDTH + 2;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);

    logic [CW-1:0]        credits;
    logic                 accept;
    logic                 pop;
    logic                 push;
    logic                 wr_en;
    logic                 full;
    logic                 empty;
    logic [SBW-1:0]       dl [LATENCY];
    logic [SBW-1:0]       tap;
    logic                 tap_valid;
    logic                 tap_last;
    logic [STRBWIDTH-1:0] tap_strb;
    logic [AW:0]          wptr;
    logic [AW:0]          rptr;
    logic [EW-1:0]        mem [DEPTH];
    logic [EW-1:0]        head;

    assign bus.s_ready = (credits != '0);
    assign accept      = bus.s_valid & bus.s_ready;
    assign bus.c_valid = accept;
    assign pop         = bus.m_tvalid & bus.m_tready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            credits <= CW'(DEPTH);
        end else if (accept && !pop) begin
            credits <= credits - CRED_ONE;
        end else if (pop && !accept) begin
            credits <= credits + CRED_ONE;
        end
    end

    // Sideband travels alongside the cipher so the last stage lines up with c_o_valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0] <= {accept, bus.s_last, bus.s_strb};
            for (int i = 1; i < LATENCY; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    assign tap       = dl[LATENCY-1];
    assign tap_valid = tap[SBW-1];
    assign tap_last  = tap[STRBWIDTH];
    assign tap_strb  = tap[STRBWIDTH-1:0];

    assign push  = bus.c_o_valid & tap_valid;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // When full, a simultaneous pop frees the head slot, which is exactly the slot being written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= {bus.c_o_block, tap_last, tap_strb};
        end
    end

    assign head         = mem[rptr[AW-1:0]];
    assign bus.m_tvalid = !empty;
    assign bus.m_tdata  = head[EW-1 -: BW];
    assign bus.m_tlast  = head[STRBWIDTH];
    assign bus.m_tstrb  = head[STRBWIDTH-1:0];

`ifdef AES_EGRESS_CHECK_EN
    logic error_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            error_q <= 1'b0;
        end else if ((bus.c_o_valid != tap_valid) || (push && full && !pop)) begin
            error_q <= 1'b1;
        end
    end

    assign bus.o_error = error_q;
`else
    assign bus.o_error = 1'b0;
`endif

endmodule
